// File: rtl/vend_io_controller.sv
// Vending I/O controller: edge-captured coin/refund events queued for the CPU,
// memory-mapped status and output registers, pulse shaping and a pacing tick.
module vend_io_controller #(
    parameter int TICK_PERIOD  = 16,
    parameter int QUEUE_DEPTH  = 4,
    parameter int PULSE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        nickel,
    input  logic        dime,
    input  logic        refund,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_value,
    output logic [31:0] mem_read_value,
    output logic        nickel_out,
    output logic        dime_out,
    output logic        vend,
    output logic        tick,
    output logic        overflow
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int TW = $clog2(TICK_PERIOD);
    localparam int HW = $clog2(PULSE_CYCLES + 1);

    localparam logic [31:0]   ADDR_EVENT  = 32'h0000_1000;
    localparam logic [31:0]   ADDR_STATUS = 32'h0000_1004;
    localparam logic [31:0]   ADDR_OUTPUT = 32'h0000_1008;
    localparam logic [CW-1:0] DEPTH_C     = CW'(QUEUE_DEPTH);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_INIT   = HW'(PULSE_CYCLES);

    logic [2:0]    prev_q, prev_d, pend_q, pend_d;
    logic [2:0]    rise, sel;
    logic [4:0]    fifo_q [QUEUE_DEPTH];
    logic [4:0]    fifo_d [QUEUE_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          tpend_q, tpend_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    out_q, out_d;

    logic          is_event, is_status, is_output;
    logic          empty, full, pop, push, status_rd, wr_out;
    logic [4:0]    push_code, head;
    logic [31:0]   cnt_w;
    logic [2:0]    cnt_sat;
    logic          unused_wdata;

    assign unused_wdata = ^mem_write_value[31:5];

    assign is_event  = (mem_address == ADDR_EVENT);
    assign is_status = (mem_address == ADDR_STATUS);
    assign is_output = (mem_address == ADDR_OUTPUT);
    assign status_rd = mem_read_en & is_status;
    assign wr_out    = mem_write_en & is_output;
    assign tick      = (tcnt_q == TICK_LAST);

    always_comb begin
        prev_d    = {refund, dime, nickel};
        rise      = {refund, dime, nickel} & ~prev_q;
        empty     = (cnt_q == '0);
        full      = (cnt_q == DEPTH_C);
        pop       = mem_read_en & is_event & ~empty;
        sel       = '0;
        push_code = '0;
        // A pop in the same cycle frees the slot the push will use.
        if (!full || pop) begin
            if (pend_q[0]) begin
                sel       = 3'b001;
                push_code = 5'h05;
            end else if (pend_q[1]) begin
                sel       = 3'b010;
                push_code = 5'h0A;
            end else if (pend_q[2]) begin
                sel       = 3'b100;
                push_code = 5'h10;
            end
        end
        push   = |sel;
        pend_d = (pend_q & ~sel) | rise;
        ovf_d  = ovf_q | (|(rise & pend_q & ~sel));
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_q] = push_code;
        end
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        head  = empty ? 5'h00 : fifo_q[rd_q];
    end

    always_comb begin
        tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
        tpend_d = tpend_q;
        if (tick) begin
            tpend_d = 1'b1;
        end else if (status_rd) begin
            tpend_d = 1'b0;
        end
    end

    always_comb begin
        out_d  = out_q;
        hold_d = hold_q;
        if (wr_out) begin
            out_d  = {mem_write_value[4],
                      mem_write_value[1] & mem_write_value[3],
                      mem_write_value[0] & mem_write_value[2]};
            hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
                out_d = '0;
            end
        end
    end

    always_comb begin
        cnt_w          = 32'(cnt_q);
        cnt_sat        = (cnt_w > 32'd7) ? 3'd7 : cnt_w[2:0];
        mem_read_value = '0;
        unique case (1'b1)
            is_event:  mem_read_value = {27'b0, head};
            is_status: mem_read_value = {26'b0, tpend_q, ovf_q, cnt_sat, ~empty};
            default:   mem_read_value = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            pend_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tpend_q <= 1'b0;
            tcnt_q  <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tpend_q <= tpend_d;
            tcnt_q  <= tcnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign nickel_out = out_q[0];
    assign dime_out   = out_q[1];
    assign vend       = out_q[2];
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vend_io_controller.sv
// Directed bench for vend_io_controller: ticks, event queue, overflow,
// output pulses and asynchronous reset.
module tb_vend_io_controller;
    localparam logic [31:0] EV = 32'h1000;
    localparam logic [31:0] ST = 32'h1004;
    localparam logic [31:0] OU = 32'h1008;
    localparam logic [31:0] MK = 32'hFFFF_FFDF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        nickel = 1'b0, dime = 1'b0, refund = 1'b0;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [31:0] mem_address = '0, mem_write_value = '0;
    logic [31:0] mem_read_value;
    logic        nickel_out, dime_out, vend, tick, overflow;
    logic [31:0] d;
    int          total = 0;
    int          bad = 0;

    vend_io_controller dut (
        .clock(clock), .reset_n(reset_n),
        .nickel(nickel), .dime(dime), .refund(refund),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_write_value(mem_write_value),
        .mem_read_value(mem_read_value),
        .nickel_out(nickel_out), .dime_out(dime_out), .vend(vend),
        .tick(tick), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
        mem_address = a;
        mem_read_en = 1'b1;
        #1;
        v = mem_read_value;
        @(posedge clock);
        #1;
        mem_read_en = 1'b0;
        mem_address = '0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        mem_address = a;
        #1;
        v = mem_read_value;
        mem_address = '0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
        mem_address     = a;
        mem_write_value = v;
        mem_write_en    = 1'b1;
        @(posedge clock);
        #1;
        mem_write_en    = 1'b0;
        mem_address     = '0;
        mem_write_value = '0;
    endtask

    function automatic logic [31:0] outs();
        return {29'b0, vend, dime_out, nickel_out};
    endfunction

    initial begin
        #1 reset_n = 1'b0;
        #1;
        peek(EV, d);
        chk("rst_event", d, 32'h0);
        peek(ST, d);
        chk("rst_status", d, 32'h0);
        chk("rst_outs", outs(), 32'h0);
        chk("rst_tick_ovf", {30'b0, tick, overflow}, 32'h0);
        #5 reset_n = 1'b1;

        for (int n = 1; n <= 48; n++) begin
            cyc(1);
            chk($sformatf("tick_%0d", n), {31'b0, tick},
                {31'b0, (n == 15 || n == 31 || n == 47)});
        end
        bus_rd(ST, d);
        chk("tpend_set", d, 32'h20);
        bus_rd(ST, d);
        chk("tpend_clr", d, 32'h0);
        cyc(13);
        chk("tick_63", {31'b0, tick}, 32'h1);
        bus_rd(ST, d);
        chk("tpend_coinc_rd", d, 32'h0);
        bus_rd(ST, d);
        chk("tpend_set_wins", d, 32'h20);

        nickel = 1'b1;
        cyc(1);
        nickel = 1'b0;
        peek(ST, d);
        chk("nk_pending_only", d & MK, 32'h0);
        cyc(1);
        peek(ST, d);
        chk("nk_status_one", d & MK, 32'h03);
        bus_rd(EV, d);
        chk("nk_event", d, 32'h05);
        peek(ST, d);
        chk("nk_status_after", d & MK, 32'h0);
        peek(EV, d);
        chk("nk_empty_event", d, 32'h0);

        {nickel, dime, refund} = 3'b111;
        cyc(1);
        {nickel, dime, refund} = 3'b000;
        cyc(1);
        bus_rd(EV, d);
        chk("sim_ev0", d, 32'h05);
        bus_rd(EV, d);
        chk("sim_ev1", d, 32'h0A);
        bus_rd(EV, d);
        chk("sim_ev2", d, 32'h10);
        bus_rd(EV, d);
        chk("sim_ev3_empty", d, 32'h0);
        peek(32'h0000_2000, d);
        chk("unmapped_rd", d, 32'h0);

        for (int i = 0; i < 4; i++) begin
            dime = 1'b1;
            cyc(1);
            dime = 1'b0;
            cyc(1);
        end
        peek(ST, d);
        chk("full_status", d & MK, 32'h09);
        dime = 1'b1;
        cyc(1);
        dime = 1'b0;
        cyc(1);
        chk("fifth_no_ovf", {31'b0, overflow}, 32'h0);
        peek(ST, d);
        chk("fifth_status", d & MK, 32'h09);
        dime = 1'b1;
        cyc(1);
        dime = 1'b0;
        chk("sixth_ovf", {31'b0, overflow}, 32'h1);
        peek(ST, d);
        chk("sixth_status", d & MK, 32'h19);
        for (int i = 0; i < 5; i++) begin
            bus_rd(EV, d);
            chk($sformatf("drain_%0d", i), d, 32'h0A);
        end
        bus_rd(EV, d);
        chk("drain_empty", d, 32'h0);
        peek(ST, d);
        chk("ovf_sticky", d & MK, 32'h10);

        bus_wr(OU, 32'h1F);
        chk("pulse_k0", outs(), 32'h7);
        cyc(7);
        chk("pulse_k7", outs(), 32'h7);
        bus_wr(OU, 32'h0A);
        chk("rewr_k8", outs(), 32'h2);
        cyc(15);
        chk("rewr_k23", outs(), 32'h2);
        cyc(1);
        chk("rewr_k24_low", outs(), 32'h0);
        bus_wr(OU, 32'h1F);
        chk("pulse_again", outs(), 32'h7);
        bus_wr(OU, 32'h0);
        chk("write_zero", outs(), 32'h0);
        bus_wr(32'h0000_100C, 32'h1F);
        chk("unmapped_wr", outs(), 32'h0);
        bus_wr(OU, 32'h05);
        chk("nickel_only", outs(), 32'h1);

        {nickel, dime, refund} = 3'b111;
        cyc(1);
        {nickel, dime, refund} = 3'b000;
        cyc(3);
        peek(ST, d);
        chk("three_queued", d & MK, 32'h17);
        chk("pulse_live", outs(), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", outs(), 32'h0);
        peek(ST, d);
        chk("mid_rst_status", d, 32'h0);
        peek(EV, d);
        chk("mid_rst_event", d, 32'h0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        peek(EV, d);
        chk("post_rst_event", d, 32'h0);
        peek(ST, d);
        chk("post_rst_status", d, 32'h0);
        chk("post_rst_outs", outs(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vend_io_controller.md
# vend_io_controller

Memory-mapped I/O controller placed between the vending-machine pins and the CPU data-memory port. It turns raw coin and refund levels into queued, loss-checked events. It decodes CPU loads and stores into event, status and output registers, and shapes CPU output writes into fixed-width pulses. It also provides a free-running pacing tick that firmware polls to hold a fixed service period.

## Interface
- `TICK_PERIOD`, 16: cycles per pacing tick, ≥2.
- `QUEUE_DEPTH`, 4: event queue entries, power of two, ≥2.
- `PULSE_CYCLES`, 16: cycles each output pulse is held, ≥1.
- `clock` in 1: single clock. All state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `nickel`, `dime`, `refund` in 1 each: synchronous input levels. Each rising edge is one event.
- `mem_read_en` in 1: CPU load strobe, one cycle per load.
- `mem_write_en` in 1: CPU store strobe.
- `mem_address` in 32: byte address.
- `mem_write_value` in 32: store data.
- `mem_read_value` out 32: load data, combinational from address and state.
- `nickel_out`, `dime_out`, `vend` out 1 each: pulsed outputs.
- `tick` out 1: one-cycle pulse every `TICK_PERIOD` cycles.
- `overflow` out 1: sticky lost-event flag.

## Operation
- **Address map** (full 32-bit compare):
  - EVENT = 0x1000, read.
  - STATUS = 0x1004, read.
  - OUTPUT = 0x1008, write.
  - Reads of any other address return 0. Writes to any other address are ignored.
- **Edge capture:** one previous-sample register per input. A rising edge sets that input's pending flag.
- **Event codes:** nickel = 0x05, dime = 0x0A, refund = 0x10, zero-extended to 32 bits.
- **Enqueue:**
  - At most one pending flag is enqueued per cycle, priority nickel > dime > refund.
  - The flag clears when its code is enqueued.
  - Enqueue is allowed if the queue is not full, or if a pop occurs in the same cycle.
- **Overflow:** a rising edge on an input whose pending flag is still set drops the event and sets the sticky `overflow`. Only reset clears `overflow`.
- **EVENT read:**
  - Returns the head code.
  - With `mem_read_en`, pops the head at the clock edge.
  - An empty queue reads 0 and does not pop.
- **STATUS read fields:**
  - bit0 = queue non-empty.
  - bits[3:1] = queue count, saturating at 7.
  - bit4 = overflow.
  - bit5 = tick_pending.
  - bits[31:6] = 0.
- **tick_pending:** set on `tick`, cleared by a STATUS read with `mem_read_en`. If set and clear occur in the same cycle, set wins.
- **OUTPUT write (latches):**
  - `nickel_out` = d[0] & d[2].
  - `dime_out` = d[1] & d[3].
  - `vend` = d[4].
  - Loads a hold counter with `PULSE_CYCLES`.
- **Pulse hold:**
  - When the counter reaches 0, all three outputs go low.
  - A write during an active pulse replaces the values and restarts the count.
  - A write with all three mapped values 0 drives outputs low immediately.
- **Tick counter:** 0..`TICK_PERIOD`-1, wrapping. `tick` = 1 when the count is `TICK_PERIOD`-1.
- **Reset:**
  - Queue empty, pending flags 0, previous-sample registers 0.
  - `overflow` 0, tick_pending 0, tick count 0, hold counter 0.
  - All outputs 0; `mem_read_value` reads 0 at EVENT.
- **Reset mid-operation:** queued and pending events are discarded and any active pulse is cut.

## Timing
- An input high at edge k and low at edge k-1 sets pending at edge k. The event is enqueued at edge k+1 if space allows and is visible on an EVENT read during cycle k+1.
- Simultaneous nickel and dime edges at edge k enqueue nickel at k+1 and dime at k+2.
- Pop takes effect at the edge closing the read cycle. The next head is visible the following cycle.
- Store at edge k: outputs take the new values after edge k and stay for exactly `PULSE_CYCLES` cycles, low after edge k+`PULSE_CYCLES`.
- `tick` first asserts `TICK_PERIOD`-1 cycles after reset release, then every `TICK_PERIOD` cycles.
- Throughput: one enqueue and one pop per cycle.

## Test plan
- **Single nickel:** nickel 0→1 at cycle 2, EVENT read at cycle 4 → read 0x05. STATUS bit0 = 0 afterward.
- **Simultaneous edges:** nickel, dime and refund rise on the same cycle, then three EVENT reads → 0x05, 0x0A, 0x10 in order, then 0.
- **Full queue:** 4 dime edges with no reads, then 2 more dime edges spaced 2 cycles apart.
  - The 5th edge is held pending with no loss.
  - The 6th edge sets `overflow`.
  - STATUS reads 0x19 (count 4, bit4, queue non-empty).
- **Output pulses:** write 0x1F → `nickel_out`, `dime_out` and `vend` high for 16 cycles.
  - Rewrite with 0x0A at cycle 8 → `dime_out` only, held 16 more cycles.
  - Write 0 → all outputs low the next cycle.
- **Tick and read-to-clear:** `tick` at cycles 15, 31, 47 after reset release.
  - STATUS read → bit5 = 1, then reads 0 on the next read.
  - A STATUS read coinciding with `tick` leaves bit5 = 1.
- **Reset mid-operation:** assert `reset_n` low with 3 events queued and a pulse active → all outputs 0 and STATUS 0 asynchronously. After release, EVENT reads 0.
